// File: rtl/asic_freq_pkg.sv
// Shared constants for the frequency counter: register map, reset values,
// display geometry and the hex to 7-segment decode.
package asic_freq_pkg;

    localparam logic [3:0] ADDR_DIVIDER = 4'd0;
    localparam logic [3:0] ADDR_PERIOD  = 4'd1;
    localparam logic [3:0] ADDR_MODE    = 4'd2;
    localparam logic [3:0] ADDR_DIGITS  = 4'd3;
    localparam logic [3:0] ADDR_DIGIT8  = 4'd4;
    localparam logic [3:0] ADDR_DP      = 4'd5;

    localparam logic [31:0] DIVIDER_MIN   = 32'd4;
    localparam logic [31:0] DIVIDER_RESET = 32'd4;
    localparam logic [31:0] PERIOD_RESET  = 32'd1000;

    localparam logic [3:0] LAST_COL = 4'd8;

    typedef enum logic {
        DISP_HEX    = 1'b0,
        DISP_DIGITS = 1'b1
    } disp_mode_t;

    // Segment bits [6:0] = g..a, active high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first. The bit time is captured from divider
// when a byte starts, so divider changes only affect the next byte.
module uart_tx_byte
    import asic_freq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] divider,
    input  logic [7:0]  data,
    input  logic        start,
    output logic        tx,
    output logic        busy
);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    tx_state_t   state, state_next;
    logic [31:0] div_q;
    logic [31:0] cyc_q;
    logic [9:0]  frame_q;
    logic [3:0]  bit_q;
    logic        bit_end;

    assign bit_end = (cyc_q == div_q - 32'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= TX_IDLE;
        else       state <= state_next;
    end

    // Next state: leave idle on start, return after the stop bit completes.
    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE: if (start) state_next = TX_SEND;
            TX_SEND: if (bit_end && (bit_q == 4'd9)) state_next = TX_IDLE;
            default: state_next = TX_IDLE;
        endcase
    end

    // Frame shifter and bit-time counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= DIVIDER_RESET;
            cyc_q   <= '0;
            frame_q <= '1;
            bit_q   <= '0;
        end else if (state == TX_IDLE) begin
            if (start) begin
                div_q   <= divider;
                frame_q <= {1'b1, data, 1'b0};
                cyc_q   <= '0;
                bit_q   <= '0;
            end
        end else if (bit_end) begin
            cyc_q   <= '0;
            bit_q   <= bit_q + 4'd1;
            frame_q <= {1'b1, frame_q[9:1]};
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign tx   = (state == TX_SEND) ? frame_q[0] : 1'b1;
    assign busy = (state == TX_SEND);

endmodule

// File: rtl/asic_freq_counter.sv
// Frequency counter: counts rising edges of samplee per update period,
// reports the count over UART and on a scanned 9-column 7-segment display.
module asic_freq_counter
    import asic_freq_pkg::*;
#(
    parameter int unsigned SCAN_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic [31:0] value,
    input  logic        strobe,
    input  logic        samplee,
    output logic [31:0] o,
    output logic [31:0] oc,
    output logic        tx,
    output logic [8:0]  col_drvs,
    output logic [7:0]  seg_drvs
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_LOAD = 2'd1,
        W_WAIT = 2'd2
    } word_state_t;

    logic [31:0] divider_q, period_q, digits_q;
    disp_mode_t  mode_q;
    logic [3:0]  digit8_q;
    logic [8:0]  dp_q;
    logic        wr_period;

    assign wr_period = strobe && (addr == ADDR_PERIOD);

    // Register file writes with divider clamp and zero-period guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            divider_q <= DIVIDER_RESET;
            period_q  <= PERIOD_RESET;
            mode_q    <= DISP_HEX;
            digits_q  <= '0;
            digit8_q  <= '0;
            dp_q      <= '0;
        end else if (strobe) begin
            case (addr)
                ADDR_DIVIDER: divider_q <= (value < DIVIDER_MIN) ? DIVIDER_MIN : value;
                ADDR_PERIOD:  period_q  <= (value == '0) ? 32'd1 : value;
                ADDR_MODE:    mode_q    <= disp_mode_t'(value[0]);
                ADDR_DIGITS:  digits_q  <= value;
                ADDR_DIGIT8:  digit8_q  <= value[3:0];
                ADDR_DP:      dp_q      <= value[8:0];
                default:      ;
            endcase
        end
    end

    logic s_meta, s_sync, s_prev, rise;

    // Two-flop synchroniser plus edge-detect flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s_meta <= samplee;
            s_sync <= s_meta;
            s_prev <= s_sync;
        end
    end

    assign rise = s_sync & ~s_prev;

    // Free-running edge count.
    always_ff @(posedge clk) begin
        if (reset)     oc <= '0;
        else if (rise) oc <= oc + 32'd1;
    end

    logic [31:0] timer_q, acc_q, acc_next;
    logic        period_end, o_update;

    assign acc_next   = acc_q + {31'd0, rise};
    assign period_end = (timer_q >= period_q - 32'd1);
    assign o_update   = period_end && !wr_period;

    // Period timer and accumulator; a period write restarts the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            acc_q   <= '0;
            o       <= '0;
        end else if (wr_period) begin
            timer_q <= '0;
            acc_q   <= '0;
        end else if (period_end) begin
            o       <= acc_next;
            acc_q   <= '0;
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
            acc_q   <= acc_next;
        end
    end

    word_state_t w_state, w_state_next;
    logic [31:0] word_q;
    logic [1:0]  byte_idx_q;
    logic        byte_start, uart_busy;

    // Word sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_next;
    end

    // Word sequencer: accept an update only when idle, then send 4 bytes.
    always_comb begin
        w_state_next = w_state;
        byte_start   = 1'b0;
        case (w_state)
            W_IDLE: if (o_update) w_state_next = W_LOAD;
            W_LOAD: begin
                byte_start   = 1'b1;
                w_state_next = W_WAIT;
            end
            W_WAIT: if (!uart_busy) w_state_next = (byte_idx_q == 2'd3) ? W_IDLE : W_LOAD;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Word is shifted left after each byte so the next byte is always [31:24].
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (o_update) begin
                    word_q     <= acc_next;
                    byte_idx_q <= '0;
                end
                W_WAIT: if (!uart_busy) begin
                    word_q     <= {word_q[23:0], 8'h00};
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte u_uart (
        .clk     (clk),
        .reset   (reset),
        .divider (divider_q),
        .data    (word_q[31:24]),
        .start   (byte_start),
        .tx      (tx),
        .busy    (uart_busy)
    );

    logic [SCAN_BITS-1:0] scan_q;
    logic [3:0]           col_q;

    // Column scan: advance one column each time the prescaler wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= '0;
            col_q  <= '0;
        end else begin
            scan_q <= scan_q + SCAN_BITS'(1);
            if (&scan_q) col_q <= (col_q == LAST_COL) ? 4'd0 : col_q + 4'd1;
        end
    end

    assign col_drvs = 9'b1 << col_q;

    logic [3:0] nib;

    // Segment decode for the active column.
    always_comb begin
        seg_drvs = '0;
        nib      = '0;
        if (mode_q == DISP_HEX) begin
            if (col_q != LAST_COL) begin
                nib      = 4'(o >> {col_q[2:0], 2'b00});
                seg_drvs = {1'b0, hex_to_seg(nib)};
            end
        end else begin
            nib      = (col_q == LAST_COL) ? digit8_q : 4'(digits_q >> {col_q[2:0], 2'b00});
            seg_drvs = {|(dp_q & col_drvs), hex_to_seg(nib)};
        end
    end

endmodule

// File: tb/tb_asic_freq_counter.sv
// Self-checking bench for asic_freq_counter: display vector table, edge
// counting against a reference model, UART frame decoding, reset corners.
module tb_asic_freq_counter;

    logic        clk = 1'b0;
    logic        reset, strobe, samplee;
    logic [3:0]  addr;
    logic [31:0] value;
    logic [31:0] o, oc;
    logic        tx;
    logic [8:0]  col_drvs;
    logic [7:0]  seg_drvs;

    always #5 clk = ~clk;

    asic_freq_counter #(.SCAN_BITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .value    (value),
        .strobe   (strobe),
        .samplee  (samplee),
        .o        (o),
        .oc       (oc),
        .tx       (tx),
        .col_drvs (col_drvs),
        .seg_drvs (seg_drvs)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an input level seen at edge m is counted at edge m+2
    // if it is high and the level seen at edge m-1 was low. The window closes
    // every 'period' edges since the last restart.
    logic [2:0]  seen;
    logic        inc_m;
    logic [31:0] oc_m, o_m, win_m, period_m;
    int unsigned since_restart;
    int unsigned reset_count = 0;
    logic [31:0] upd_q[$];

    always @(posedge clk) begin
        if (reset) begin
            seen          = '0;
            oc_m          = '0;
            o_m           = '0;
            win_m         = '0;
            period_m      = 32'd1000;
            since_restart = 0;
            reset_count++;
        end else begin
            inc_m = seen[1] & ~seen[2];
            oc_m  = oc_m + 32'(inc_m);
            if (strobe && addr == 4'd1) begin
                period_m      = (value == 32'd0) ? 32'd1 : value;
                since_restart = 0;
                win_m         = '0;
            end else begin
                win_m = win_m + 32'(inc_m);
                since_restart++;
                if (since_restart == period_m) begin
                    o_m           = win_m;
                    win_m         = '0;
                    since_restart = 0;
                    upd_q.push_back(o_m);
                end
            end
            seen = {seen[1:0], samplee};
        end
    end

    bit          chk_en = 1'b0;
    int unsigned smode  = 0;
    int unsigned tcnt   = 0;

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("o", o, o_m);
            chk("oc", oc, oc_m);
        end
        case (smode)
            0: samplee = 1'b0;
            1: begin
                tcnt++;
                if (tcnt == 5) begin
                    tcnt    = 0;
                    samplee = ~samplee;
                end
            end
            default: samplee = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        addr   = a;
        value  = v;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic wait_col(input int unsigned c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (col_drvs == 9'(9'b1 << c)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk($sformatf("col_wait[%0d]", c), 32'(ok), 32'd1);
    endtask

    // UART decoder with 4-clk bits, sampling mid-bit from the negedge the
    // start bit is first seen. Frames interrupted by reset are discarded.
    int unsigned words_ok = 0;
    int unsigned next_idx = 0;

    initial begin
        bit          tx_prev;
        bit          start_bit, stop_bit, found;
        logic [7:0]  b;
        logic [31:0] word;
        int unsigned nb, rc, word_rc;
        tx_prev = 1'b1;
        nb      = 0;
        word    = '0;
        word_rc = 0;
        forever begin
            @(negedge clk);
            if (tx_prev && !tx && !reset) begin
                rc = reset_count;
                repeat (2) @(negedge clk);
                start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                stop_bit = tx;
                if (rc == reset_count) begin
                    chk("uart_start", 32'(start_bit), 32'd0);
                    chk("uart_stop", 32'(stop_bit), 32'd1);
                    if (nb == 0 || word_rc != rc) begin
                        nb      = 0;
                        word_rc = rc;
                    end
                    word = {word[23:0], b};
                    nb++;
                    if (nb == 4) begin
                        nb    = 0;
                        found = 1'b0;
                        for (int i = int'(next_idx); i < upd_q.size(); i++) begin
                            if (upd_q[i] == word) begin
                                found    = 1'b1;
                                next_idx = i + 1;
                                break;
                            end
                        end
                        n_checks++;
                        if (found) words_ok++;
                        else begin
                            n_errors++;
                            $display("FAIL uart_word: decoded %h, expected one of the pending o updates (%0d recorded)",
                                     word, upd_q.size());
                        end
                    end
                end else begin
                    nb = 0;
                end
            end
            tx_prev = tx;
        end
    end

    typedef struct {
        logic [3:0]  a;
        logic [31:0] v;
        int unsigned col;
        logic [7:0]  seg;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] oc0;
        int unsigned low_cnt, w;

        reset   = 1'b1;
        strobe  = 1'b0;
        addr    = '0;
        value   = '0;
        samplee = 1'b0;

        tbl[0]  = '{4'd3,  32'h7654_3210, 3, 8'h3F};
        tbl[1]  = '{4'd2,  32'h0000_0001, 3, 8'h4F};
        tbl[2]  = '{4'd5,  32'h0000_01FF, 3, 8'hCF};
        tbl[3]  = '{4'd4,  32'h0000_0008, 8, 8'hFF};
        tbl[4]  = '{4'd5,  32'h0000_0000, 8, 8'h7F};
        tbl[5]  = '{4'd3,  32'hFEDC_BA98, 0, 8'h7F};
        tbl[6]  = '{4'd13, 32'h0000_01FF, 1, 8'h6F};
        tbl[7]  = '{4'd5,  32'h0000_0020, 5, 8'hDE};
        tbl[8]  = '{4'd4,  32'h0000_000A, 8, 8'h77};
        tbl[9]  = '{4'd10, 32'h0000_0000, 7, 8'h71};
        tbl[10] = '{4'd2,  32'hFFFF_FFFE, 8, 8'h00};
        tbl[11] = '{4'd15, 32'hFFFF_FFFF, 0, 8'h3F};

        repeat (3) tick();
        reset = 1'b0;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_o", o, 32'd0);
        chk("reset_oc", oc, 32'd0);
        chk("reset_col", 32'(col_drvs), 32'h001);
        chk_en = 1'b1;

        // Column walk with a 4-cycle dwell.
        for (int unsigned j = 0; j < 40; j++) begin
            chk($sformatf("col_walk[%0d]", j), 32'(col_drvs), 32'd1 << ((j / 4) % 9));
            tick();
        end

        // Display register vectors.
        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].a, tbl[i].v);
            wait_col(tbl[i].col);
            chk($sformatf("seg[%0d]", i), 32'(seg_drvs), 32'(tbl[i].seg));
        end

        // Quiet input: nothing counted, link idle once the zero words are out.
        wr(4'd1, 32'd1000);
        oc0     = oc;
        low_cnt = 0;
        for (int i = 0; i < 2300; i++) begin
            tick();
            if (i >= 2200 && !tx) low_cnt++;
        end
        chk("quiet_o", o, 32'd0);
        chk("quiet_oc", oc, oc0);
        chk("quiet_tx_low_cycles", low_cnt, 32'd0);

        // Square wave, 10-clk period, 100-clk window; divider 2 clamps to 4.
        smode = 1;
        tcnt  = 0;
        repeat (50) tick();
        wr(4'd0, 32'd2);
        wr(4'd1, 32'd100);
        repeat (700) tick();
        chk("steady_o", o, 32'd10);
        oc0 = oc;
        repeat (100) tick();
        chk("oc_per_100", oc - oc0, 32'd10);
        wait_col(0);
        chk("hex_col0", 32'(seg_drvs), 32'h77);
        wait_col(1);
        chk("hex_col1", 32'(seg_drvs), 32'h3F);
        wait_col(8);
        chk("hex_col8", 32'(seg_drvs), 32'h00);

        // Random input with random windows, then the minimum window.
        smode = 2;
        for (int r = 0; r < 3; r++) begin
            wr(4'd1, 32'($urandom_range(20, 200)));
            repeat (500) tick();
        end
        wr(4'd1, 32'd0);
        repeat (60) tick();

        // Reset in the middle of a UART byte and a counting window.
        w = 0;
        while (tx && w < 400) begin
            tick();
            w++;
        end
        chk("tx_goes_low", 32'(tx), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_o", o, 32'd0);
        chk("midrst_oc", oc, 32'd0);
        chk("midrst_col", 32'(col_drvs), 32'h001);
        smode = 0;
        repeat (20) tick();
        chk("midrst_tx_idle", 32'(tx), 32'd1);
        chk("uart_words_seen", 32'(words_ok != 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
